// File: rtl/md_sched.sv
// md_sched: HI/LO owner and multi-cycle mult/div scheduler beside the EX ALU.
// Optional MDU_DIVZERO_EN: zero divisor finishes in one cycle, hi=rs, lo=all ones.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_md_op,
    input  logic [31:0] E_rs_val,
    input  logic [31:0] E_rt_val,
    input  logic        D_md_use,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rdata
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [15:0] count, count_n;
    logic [31:0] hi_n, lo_n;
    logic [31:0] sh_hi, sh_lo, sh_hi_n, sh_lo_n;
    logic        commit, commit_n;

    logic        is_mul, is_div, div_zero;
    logic [63:0] op_a, op_b, prod;
    logic [31:0] dvs, uq, ur;
    logic [32:0] sq, sr;

    assign is_mul   = (E_md_op == 4'd1) || (E_md_op == 4'd2);
    assign is_div   = (E_md_op == 4'd3) || (E_md_op == 4'd4);
    assign div_zero = is_div && (E_rt_val == 32'd0);

    assign start = (is_mul || is_div) && (state == IDLE);
    assign busy  = (state == RUN);
    assign stall = D_md_use & (start | busy);

    always_comb begin
        md_rdata = 32'd0;
        if (E_md_op == 4'd7) md_rdata = hi;
        else if (E_md_op == 4'd8) md_rdata = lo;
    end

    // Low 64 bits of the product are sign-correct once operands are extended.
    assign op_a = (E_md_op == 4'd1) ? {{32{E_rs_val[31]}}, E_rs_val}
                                    : {32'd0, E_rs_val};
    assign op_b = (E_md_op == 4'd1) ? {{32{E_rt_val[31]}}, E_rt_val}
                                    : {32'd0, E_rt_val};
    assign prod = op_a * op_b;

    // 33-bit signed divide avoids the -2^31 / -1 overflow corner.
    assign dvs = (E_rt_val == 32'd0) ? 32'd1 : E_rt_val;
    assign sq  = $signed({E_rs_val[31], E_rs_val}) / $signed({dvs[31], dvs});
    assign sr  = $signed({E_rs_val[31], E_rs_val}) % $signed({dvs[31], dvs});
    assign uq  = E_rs_val / dvs;
    assign ur  = E_rs_val % dvs;

    always_comb begin
        state_n  = state;
        count_n  = count;
        hi_n     = hi;
        lo_n     = lo;
        sh_hi_n  = sh_hi;
        sh_lo_n  = sh_lo;
        commit_n = commit;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = RUN;
                    commit_n = 1'b1;
                    if (is_mul) begin
                        count_n = 16'(MULT_CYCLES);
                        sh_hi_n = prod[63:32];
                        sh_lo_n = prod[31:0];
                    end else begin
                        count_n = 16'(DIV_CYCLES);
                        if (E_md_op == 4'd3) begin
                            sh_hi_n = sr[31:0];
                            sh_lo_n = sq[31:0];
                        end else begin
                            sh_hi_n = ur;
                            sh_lo_n = uq;
                        end
`ifdef MDU_DIVZERO_EN
                        if (div_zero) begin
                            count_n = 16'd1;
                            sh_hi_n = E_rs_val;
                            sh_lo_n = 32'hFFFF_FFFF;
                        end
`else
                        if (div_zero) commit_n = 1'b0;
`endif
                    end
                end else if (E_md_op == 4'd5) begin
                    hi_n = E_rs_val;
                end else if (E_md_op == 4'd6) begin
                    lo_n = E_rs_val;
                end
            end
            RUN: begin
                count_n = count - 16'd1;
                if (count == 16'd1) begin
                    state_n = IDLE;
                    if (commit) begin
                        hi_n = sh_hi;
                        lo_n = sh_lo;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= 16'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            sh_hi  <= 32'd0;
            sh_lo  <= 32'd0;
            commit <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            hi     <= hi_n;
            lo     <= lo_n;
            sh_hi  <= sh_hi_n;
            sh_lo  <= sh_lo_n;
            commit <= commit_n;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: scoreboard bench for md_sched with a queue-based reference model.
// Honours MDU_DIVZERO_EN the same way the design does.
module tb_md_sched;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_md_op;
    logic [31:0] E_rs_val, E_rt_val;
    logic        D_md_use;
    logic        start, busy, stall;
    logic [31:0] hi, lo, md_rdata;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .E_md_op(E_md_op),
        .E_rs_val(E_rs_val), .E_rt_val(E_rt_val), .D_md_use(D_md_use),
        .start(start), .busy(busy), .stall(stall),
        .hi(hi), .lo(lo), .md_rdata(md_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        busy;
        logic [31:0] rdata;
        logic [31:0] hi;
        logic [31:0] lo;
    } cyc_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } res_t;

    cyc_t cyc_q[$];
    res_t res_q[$];

    int total = 0;
    int bad   = 0;
    bit mon_on = 0;

    // Architectural model: HI/LO plus remaining busy cycles and pending result
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int          m_left = 0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
        end
    endfunction

    function automatic void calc(input logic [3:0] op,
                                 input logic [31:0] a, b,
                                 output logic [31:0] h, l,
                                 output int n, output bit cm);
        longint          sp, sa, sb, q, r;
        longint unsigned up;
        cm = 1;
        n  = (op <= 4'd2) ? MC : DC;
        h  = 0;
        l  = 0;
        case (op)
            4'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                h = sp[63:32]; l = sp[31:0];
            end
            4'd2: begin
                up = 64'(a) * 64'(b);
                h = up[63:32]; l = up[31:0];
            end
            default: begin
                if (b == 0) begin
`ifdef MDU_DIVZERO_EN
                    n = 1; h = a; l = 32'hFFFF_FFFF;
`else
                    cm = 0;
`endif
                end else if (op == 4'd3) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q = sa / sb; r = sa % sb;
                    h = r[31:0]; l = q[31:0];
                end else begin
                    h = a % b; l = a / b;
                end
            end
        endcase
    endfunction

    task automatic cyc(input logic r, input logic [3:0] op,
                       input logic [31:0] rs, rt, input logic du);
        cyc_t e;
        res_t x;
        logic st, bz;
        logic [31:0] h, l;
        int n;
        bit cm;
        @(posedge clk);
        #1;
        reset = r; E_md_op = op; E_rs_val = rs; E_rt_val = rt; D_md_use = du;
        bz = (m_left > 0);
        st = (op >= 4'd1 && op <= 4'd4) && !bz;
        e.stall = du & (st | bz);
        e.busy  = bz;
        e.rdata = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
        e.hi    = m_hi;
        e.lo    = m_lo;
        cyc_q.push_back(e);
        if (r) begin
            m_hi = 0; m_lo = 0; m_left = 0;
            res_q.delete();
        end else if (bz) begin
            m_left--;
            if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (st) begin
            calc(op, rs, rt, h, l, n, cm);
            p_hi = cm ? h : m_hi;
            p_lo = cm ? l : m_lo;
            m_left = n;
            x.hi = p_hi; x.lo = p_lo; x.n = n;
            res_q.push_back(x);
        end else if (op == 4'd5) begin
            m_hi = rs;
        end else if (op == 4'd6) begin
            m_lo = rs;
        end
    endtask

    task automatic idle(input int n, input logic du);
        for (int i = 0; i < n; i++) cyc(0, 4'd0, $urandom, $urandom, du);
    endtask

    // Monitor: per-cycle outputs, plus HI/LO and busy length at each completion
    int   run = 0;
    logic prev_busy = 0, prev_rst = 0;

    always @(negedge clk) begin
        cyc_t e;
        res_t x;
        if (mon_on) begin
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("stall", {31'd0, stall}, {31'd0, e.stall});
                chk("busy", {31'd0, busy}, {31'd0, e.busy});
                chk("md_rdata", md_rdata, e.rdata);
                chk("hi_cyc", hi, e.hi);
                chk("lo_cyc", lo, e.lo);
            end
            if (busy) begin
                run++;
            end else begin
                if (prev_busy && !prev_rst) begin
                    if (res_q.size() == 0) begin
                        chk("res_underflow", 32'd1, 32'd0);
                    end else begin
                        x = res_q.pop_front();
                        chk("res_hi", hi, x.hi);
                        chk("res_lo", lo, x.lo);
                        chk("busy_len", 32'(run), 32'(x.n));
                    end
                end
                run = 0;
            end
            prev_busy = busy;
            prev_rst  = reset;
        end
    end

    logic [31:0] specials [4] = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};

    function automatic logic [31:0] rval();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    initial begin
        logic [3:0] op;
        reset = 1; E_md_op = 0; E_rs_val = 0; E_rt_val = 0; D_md_use = 0;
        cyc(1, 4'd0, 0, 0, 0);
        @(negedge clk);
        cyc_q.delete();
        mon_on = 1;
        cyc(1, 4'd0, 0, 0, 0);
        cyc(0, 4'd7, 0, 0, 0);
        cyc(0, 4'd8, 0, 0, 0);
        // signed, unsigned mult; signed div with ID stall held
        cyc(0, 4'd1, 32'hFFFF_FFFE, 32'd3, 0);
        idle(MC + 1, 0);
        cyc(0, 4'd2, 32'hFFFF_FFFF, 32'd2, 0);
        idle(MC + 1, 0);
        cyc(0, 4'd3, 32'hFFFF_FFF9, 32'd2, 1);
        idle(DC + 2, 1);
        // zero divisor with known prior HI/LO
        cyc(0, 4'd5, 32'h11, 0, 0);
        cyc(0, 4'd6, 32'h11, 0, 0);
        cyc(0, 4'd3, 32'd5, 32'd0, 1);
        idle(DC + 1, 1);
        cyc(0, 4'd7, 0, 0, 0);
        cyc(0, 4'd8, 0, 0, 0);
        // reset abandons a running mult
        cyc(0, 4'd1, 32'h1234_5678, 32'h9, 0);
        idle(2, 0);
        cyc(1, 4'd0, 0, 0, 0);
        cyc(0, 4'd0, 0, 0, 0);
        cyc(0, 4'd5, 32'h1234, 0, 0);
        cyc(0, 4'd0, 0, 0, 1);
        cyc(0, 4'd7, 0, 0, 1);
        // start and mthi attempted during RUN are ignored
        cyc(0, 4'd4, 32'd100, 32'd7, 1);
        cyc(0, 4'd1, 32'd3, 32'd3, 1);
        cyc(0, 4'd5, 32'hDEAD, 0, 1);
        idle(DC, 1);
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 9) < 6) ? 4'd0 : 4'($urandom_range(0, 15));
            cyc($urandom_range(0, 149) == 0, op, rval(), rval(), 1'($urandom));
        end
        idle(DC + 2, 0);
        @(negedge clk);
        #1;
        chk("res_q_empty", 32'(res_q.size()), 32'd0);
        chk("cyc_q_empty", 32'(cyc_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
